// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   REG_AW_DEF   : default register address width (RegAddrBus width)
//   hzd_state_e  : controller FSM state encodings (2 bits)
//   FWD_*        : EXE operand forwarding select encodings
//   fwd_select() : forwarding priority helper (EXE result beats MEM result)
package pipeline_hazard_ctrl_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    HZD_RUN   = 2'd0,
    HZD_LU    = 2'd1,
    HZD_FLUSH = 2'd2,
    HZD_WAIT  = 2'd3
  } hzd_state_e;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXEMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB  = 2'b10;

  // The producer currently in EXE is the youngest, so its value wins.
  function automatic logic [1:0] fwd_select(input logic exe_match, input logic mem_match);
    if (exe_match)      return FWD_EXEMEM;
    else if (mem_match) return FWD_MEMWB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_match.sv
// hazard_match: combinational RAW comparator between one ID source and one
// producer destination. x0 never matches.
//   i_src      : source register address
//   i_src_used : instruction actually reads the source
//   i_dst      : producer destination address
//   i_dst_wen  : producer writes its destination
//   o_match    : RAW dependency present
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_src_used,
  input  logic [REG_AW-1:0] i_dst,
  input  logic              i_dst_wen,
  output logic              o_match
);

  assign o_match = i_src_used && (i_src != '0) && i_dst_wen && (i_src == i_dst);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: central hazard controller for the 5-stage rv32 core.
// Detects RAW hazards between ID sources and EXE/MEM destinations, produces
// registered EXE forwarding selects and the stall/bubble/flush controls for
// the IFID/IDEXE/EXEMEM/MEMWB registers. Sequences load-use stalls, redirect
// flushes and data-memory wait holds.
// Optional feature: define HZD_PERF_CNT_EN to add saturating perf counters.
// Ports:
//   clk_i_core, reset_i_core (sync, active-high)
//   id_rs1_i/id_rs2_i, id_rs1_used_i/id_rs2_used_i : ID sources
//   exe_rd_i, exe_wen_i, exe_is_load_i             : EXE producer
//   mem_rd_i, mem_wen_i                            : MEM producer
//   exe_redirect_i, mem_busy_i                     : control events
//   pc_stall_o, ifid_stall_o, ifid_flush_o, idexe_bubble_o,
//   exemem_stall_o, memwb_bubble_o                 : pipeline controls
//   fwd_a_o, fwd_b_o                               : registered EXE fwd selects
//   perf_stall_o, perf_flush_o                     : perf counters (HZD_PERF_CNT_EN)
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = REG_AW_DEF,
  parameter int FLUSH_CYCLES = 1
`ifdef HZD_PERF_CNT_EN
  ,
  parameter int PERF_W       = 32
`endif
) (
  input  logic              clk_i_core,
  input  logic              reset_i_core,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] exe_rd_i,
  input  logic              exe_wen_i,
  input  logic              exe_is_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_wen_i,
  input  logic              exe_redirect_i,
  input  logic              mem_busy_i,
  output logic              pc_stall_o,
  output logic              ifid_stall_o,
  output logic              ifid_flush_o,
  output logic              idexe_bubble_o,
  output logic              exemem_stall_o,
  output logic              memwb_bubble_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
`endif
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  hzd_state_e r_state, w_state_n;
  logic [1:0] r_flush_cnt, w_flush_cnt_n;
  logic       r_pend_redir, w_pend_redir_n;
  logic [1:0] r_fwd_a_p1, r_fwd_b_p1;

  logic w_m_rs1_exe, w_m_rs2_exe, w_m_rs1_mem, w_m_rs2_mem;
  logic w_load_use, w_redir_eff;

  hazard_match #(.REG_AW(REG_AW)) u_m_rs1_exe (
    .i_src(id_rs1_i), .i_src_used(id_rs1_used_i),
    .i_dst(exe_rd_i), .i_dst_wen(exe_wen_i), .o_match(w_m_rs1_exe));
  hazard_match #(.REG_AW(REG_AW)) u_m_rs2_exe (
    .i_src(id_rs2_i), .i_src_used(id_rs2_used_i),
    .i_dst(exe_rd_i), .i_dst_wen(exe_wen_i), .o_match(w_m_rs2_exe));
  hazard_match #(.REG_AW(REG_AW)) u_m_rs1_mem (
    .i_src(id_rs1_i), .i_src_used(id_rs1_used_i),
    .i_dst(mem_rd_i), .i_dst_wen(mem_wen_i), .o_match(w_m_rs1_mem));
  hazard_match #(.REG_AW(REG_AW)) u_m_rs2_mem (
    .i_src(id_rs2_i), .i_src_used(id_rs2_used_i),
    .i_dst(mem_rd_i), .i_dst_wen(mem_wen_i), .o_match(w_m_rs2_mem));

  assign w_load_use  = exe_is_load_i && (w_m_rs1_exe || w_m_rs2_exe);
  // A redirect that arrived during a memory wait is applied as soon as MEM frees up.
  assign w_redir_eff = exe_redirect_i || r_pend_redir;

  // State register
  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_state      <= HZD_RUN;
      r_flush_cnt  <= 2'd0;
      r_pend_redir <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_flush_cnt  <= w_flush_cnt_n;
      r_pend_redir <= w_pend_redir_n;
    end
  end

  // Next-state logic; RUN, LU and WAIT share one event decoder (the LU penalty
  // is a single cycle, and WAIT's first non-busy cycle behaves like RUN).
  always_comb begin
    w_state_n      = r_state;
    w_flush_cnt_n  = r_flush_cnt;
    w_pend_redir_n = r_pend_redir;
    if (r_state == HZD_FLUSH) begin
      if (exe_redirect_i) begin
        w_flush_cnt_n = FLUSH_LOAD;
      end else if (r_flush_cnt <= 2'd1) begin
        w_state_n = mem_busy_i ? HZD_WAIT : HZD_RUN;
      end else begin
        w_flush_cnt_n = r_flush_cnt - 2'd1;
      end
    end else if (mem_busy_i) begin
      w_state_n      = HZD_WAIT;
      w_pend_redir_n = r_pend_redir || exe_redirect_i;
    end else if (w_redir_eff) begin
      w_pend_redir_n = 1'b0;
      w_flush_cnt_n  = FLUSH_LOAD;
      w_state_n      = (FLUSH_CYCLES > 1) ? HZD_FLUSH : HZD_RUN;
    end else if (w_load_use) begin
      w_state_n = HZD_LU;
    end else begin
      w_state_n = HZD_RUN;
    end
  end

  // Output logic; everything is forced low while reset is asserted.
  always_comb begin
    pc_stall_o     = 1'b0;
    ifid_stall_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idexe_bubble_o = 1'b0;
    exemem_stall_o = 1'b0;
    memwb_bubble_o = 1'b0;
    if (!reset_i_core) begin
      if (r_state == HZD_FLUSH) begin
        // The flush keeps clearing IFID/IDEXE; a busy memory additionally holds the back end.
        ifid_flush_o   = 1'b1;
        idexe_bubble_o = 1'b1;
        if (mem_busy_i) begin
          pc_stall_o     = 1'b1;
          ifid_stall_o   = 1'b1;
          exemem_stall_o = 1'b1;
          memwb_bubble_o = 1'b1;
        end
      end else if (mem_busy_i) begin
        pc_stall_o     = 1'b1;
        ifid_stall_o   = 1'b1;
        exemem_stall_o = 1'b1;
        memwb_bubble_o = 1'b1;
      end else if (w_redir_eff) begin
        ifid_flush_o   = 1'b1;
        idexe_bubble_o = 1'b1;
      end else if (w_load_use) begin
        pc_stall_o     = 1'b1;
        ifid_stall_o   = 1'b1;
        idexe_bubble_o = 1'b1;
      end
    end
  end

  // ID -> EXE boundary: forwarding selects follow the instruction into IDEXE.
  // A stall without a bubble (memory wait) holds IDEXE, so the selects hold too.
  always_ff @(posedge clk_i_core) begin
    if (reset_i_core || idexe_bubble_o) begin
      r_fwd_a_p1 <= FWD_RF;
      r_fwd_b_p1 <= FWD_RF;
    end else if (!pc_stall_o) begin
      r_fwd_a_p1 <= fwd_select(w_m_rs1_exe, w_m_rs1_mem);
      r_fwd_b_p1 <= fwd_select(w_m_rs2_exe, w_m_rs2_mem);
    end
  end

  assign fwd_a_o = r_fwd_a_p1;
  assign fwd_b_o = r_fwd_b_p1;

`ifdef HZD_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_stall, r_perf_flush;
  logic              w_redir_acc;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) return v + 1'b1;
    else                             return v;
  endfunction

  // A redirect counts once when its flush actually starts (or restarts).
  assign w_redir_acc = (r_state == HZD_FLUSH) ? exe_redirect_i : (!mem_busy_i && w_redir_eff);

  always_ff @(posedge clk_i_core) begin
    if (reset_i_core) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      r_perf_stall <= sat_inc(r_perf_stall, pc_stall_o);
      r_perf_flush <= sat_inc(r_perf_flush, w_redir_acc);
    end
  end

  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] rs1, rs2, erd, mrd;
  logic       u1, u2, ewen, eld, mwen, redir, busy;
  logic       pc_stall, ifid_stall, ifid_flush, idexe_bubble, exemem_stall, memwb_bubble;
  logic [1:0] fa, fb;
  logic [5:0] ctl;
`ifdef HZD_PERF_CNT_EN
  logic [31:0] perf_stall, perf_flush;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110100;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_BUSY  = 6'b110011;

  pipeline_hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk_i_core(clk), .reset_i_core(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .exe_rd_i(erd), .exe_wen_i(ewen), .exe_is_load_i(eld),
    .mem_rd_i(mrd), .mem_wen_i(mwen),
    .exe_redirect_i(redir), .mem_busy_i(busy),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idexe_bubble_o(idexe_bubble), .exemem_stall_o(exemem_stall),
    .memwb_bubble_o(memwb_bubble),
    .fwd_a_o(fa), .fwd_b_o(fb)
`ifdef HZD_PERF_CNT_EN
    , .perf_stall_o(perf_stall), .perf_flush_o(perf_flush)
`endif
  );

  assign ctl = {pc_stall, ifid_stall, ifid_flush, idexe_bubble, exemem_stall, memwb_bubble};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, required end before 200000");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] erd;
    logic       ewen, eld;
    logic [4:0] mrd;
    logic       mwen, redir, busy;
    logic [5:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(logic [4:0] a1, logic [4:0] a2, logic b1, logic b2,
                              logic [4:0] er, logic ew, logic el, logic [4:0] mr,
                              logic mw, logic rd, logic bs, logic [5:0] c,
                              logic [1:0] xa, logic [1:0] xb);
    vec_t v;
    v.rs1 = a1; v.rs2 = a2; v.u1 = b1; v.u2 = b2;
    v.erd = er; v.ewen = ew; v.eld = el; v.mrd = mr; v.mwen = mw;
    v.redir = rd; v.busy = bs; v.ctl = c; v.fa = xa; v.fb = xb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in;
    rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; erd = 0; ewen = 0; eld = 0;
    mrd = 0; mwen = 0; redir = 0; busy = 0;
  endtask

  task automatic set_in(input vec_t v);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; erd = v.erd; ewen = v.ewen;
    eld = v.eld; mrd = v.mrd; mwen = v.mwen; redir = v.redir; busy = v.busy;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_in();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //            rs1 rs2 u1 u2 erd ew el mrd mw rd bs ctl      fa     fb
    vecs[0]  = mk(0,  0,  0, 0, 0,  0, 0, 0,  0, 0, 0, C_NONE,  2'b00, 2'b00);
    vecs[1]  = mk(0,  3,  0, 1, 3,  1, 0, 0,  0, 0, 0, C_NONE,  2'b00, 2'b01);
    vecs[2]  = mk(0,  0,  0, 1, 0,  1, 0, 0,  0, 0, 0, C_NONE,  2'b00, 2'b00);
    vecs[3]  = mk(5,  0,  1, 0, 0,  0, 0, 5,  1, 0, 0, C_NONE,  2'b10, 2'b00);
    vecs[4]  = mk(7,  0,  1, 0, 7,  1, 0, 7,  1, 0, 0, C_NONE,  2'b01, 2'b00);
    vecs[5]  = mk(7,  7,  0, 0, 7,  1, 0, 7,  1, 0, 0, C_NONE,  2'b00, 2'b00);
    vecs[6]  = mk(6,  6,  1, 1, 6,  0, 0, 6,  0, 0, 0, C_NONE,  2'b00, 2'b00);
    vecs[7]  = mk(1,  9,  1, 1, 9,  1, 1, 0,  0, 0, 0, C_LU,    2'b00, 2'b00);
    vecs[8]  = mk(0,  0,  1, 1, 0,  1, 1, 0,  0, 0, 0, C_NONE,  2'b00, 2'b00);
    vecs[9]  = mk(3,  0,  1, 0, 3,  1, 0, 0,  0, 1, 0, C_FLUSH, 2'b00, 2'b00);
    vecs[10] = mk(3,  3,  1, 1, 3,  1, 0, 0,  0, 0, 1, C_BUSY,  2'b00, 2'b00);
    vecs[11] = mk(4,  0,  1, 0, 4,  1, 1, 0,  0, 1, 1, C_BUSY,  2'b00, 2'b00);
    vecs[12] = mk(4,  0,  1, 0, 4,  1, 1, 0,  0, 1, 0, C_FLUSH, 2'b00, 2'b00);
    vecs[13] = mk(4,  8,  1, 1, 5,  1, 1, 4,  1, 0, 0, C_NONE,  2'b10, 2'b00);
    vecs[14] = mk(2,  6,  1, 1, 6,  1, 0, 2,  1, 0, 0, C_NONE,  2'b10, 2'b01);

    // Reset held two cycles with busy/redirect asserted: everything stays low.
    rst = 1'b1;
    clear_in();
    busy = 1'b1; redir = 1'b1;
    tick(); #1;
    chk("reset_ctl_c1", 32'(ctl), 32'(C_NONE));
    chk("reset_fwd_a_c1", 32'(fa), 32'd0);
    chk("reset_fwd_b_c1", 32'(fb), 32'd0);
    tick(); #1;
    chk("reset_ctl_c2", 32'(ctl), 32'(C_NONE));
    rst = 1'b0;
    clear_in();

    // Single-cycle vectors, each from a freshly reset controller.
    for (int i = 0; i < 15; i++) begin
      do_reset();
      set_in(vecs[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].ctl));
      tick();
      chk($sformatf("vec%0d_fwd_a", i), 32'(fa), 32'(vecs[i].fa));
      chk($sformatf("vec%0d_fwd_b", i), 32'(fb), 32'(vecs[i].fb));
    end

    // Load-use: lw x5 in EXE, add x?,x5 in ID.
    do_reset();
    rs1 = 5; u1 = 1; erd = 5; ewen = 1; eld = 1;
    #1; chk("lu_stall", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_fwd_after_bubble", 32'(fa), 32'd0);
    // Bubble now in EXE, lw in MEM, add still in ID.
    erd = 0; ewen = 0; eld = 0; mrd = 5; mwen = 1;
    #1; chk("lu_release", 32'(ctl), 32'(C_NONE));
    tick();
    chk("lu_fwd_a_memwb", 32'(fa), 32'(2'b10));
    clear_in();

    // ALU forward into B, then it must hold through a memory wait.
    rs2 = 3; u2 = 1; erd = 3; ewen = 1;
    #1; chk("alu_no_stall", 32'(ctl), 32'(C_NONE));
    tick();
    chk("alu_fwd_b", 32'(fb), 32'(2'b01));
    clear_in();

    // Memory busy 3 cycles, redirect during the 2nd, flush follows.
    busy = 1;
    #1; chk("wait_c1", 32'(ctl), 32'(C_BUSY));
    tick();
    redir = 1;
    #1; chk("wait_c2", 32'(ctl), 32'(C_BUSY));
    chk("wait_fwd_hold", 32'(fb), 32'(2'b01));
    tick();
    redir = 0;
    #1; chk("wait_c3", 32'(ctl), 32'(C_BUSY));
    tick();
    busy = 0;
    #1; chk("wait_pending_flush_c4", 32'(ctl), 32'(C_FLUSH));
    tick();
    #1; chk("wait_pending_flush_c5", 32'(ctl), 32'(C_FLUSH));
    chk("wait_fwd_cleared", 32'(fb), 32'd0);
    tick();
    #1; chk("wait_done_c6", 32'(ctl), 32'(C_NONE));
`ifdef HZD_PERF_CNT_EN
    chk("perf_stall", perf_stall, 32'd4);
    chk("perf_flush", perf_flush, 32'd1);
`endif

    // Redirect with FLUSH_CYCLES=2: flush exactly two cycles.
    do_reset();
    redir = 1;
    #1; chk("redir_c0", 32'(ctl), 32'(C_FLUSH));
    tick();
    redir = 0;
    #1; chk("redir_c1", 32'(ctl), 32'(C_FLUSH));
    tick();
    #1; chk("redir_c2_done", 32'(ctl), 32'(C_NONE));

    // Redirect during FLUSH restarts the count.
    do_reset();
    redir = 1;
    tick();
    #1; chk("restart_c1", 32'(ctl), 32'(C_FLUSH));
    tick();
    redir = 0;
    #1; chk("restart_c2", 32'(ctl), 32'(C_FLUSH));
    tick();
    #1; chk("restart_c3_done", 32'(ctl), 32'(C_NONE));

    // Reset in the middle of a wait drops the pending redirect.
    do_reset();
    busy = 1; redir = 1;
    tick();
    rst = 1;
    #1; chk("midreset_ctl", 32'(ctl), 32'(C_NONE));
    tick();
    rst = 0;
    clear_in();
    #1; chk("midreset_no_pending", 32'(ctl), 32'(C_NONE));
`ifdef HZD_PERF_CNT_EN
    chk("midreset_perf_stall", perf_stall, 32'd0);
`endif
    tick();
    #1; chk("midreset_idle", 32'(ctl), 32'(C_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
